power_vec_scheduler: RTL and testbench

Sequences stimulus into one small combinational sub-circuit under test (4 inputs, 1 output) for switching-activity profiling in the power experiments. It walks a programmable number of input vectors in binary or Gray order and drives them on registered outputs. After a settle window it samples the sub-circuit output. It accumulates output toggles, input-bit toggles and output-high count, and returns them through a valid/ready result handshake.

---
 rtl/power_sched_pkg.sv | 37 +++
 rtl/power_vec_gen.sv | 46 ++++
 rtl/power_vec_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_power_vec_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/power_sched_pkg.sv
// Shared types, constants and helper functions for the switching-activity
// vector scheduler.
package power_sched_pkg;

    localparam int DEF_N_IN       = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 1;
    localparam int SETTLE_W       = 8;

    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic [DEF_CNT_W-1:0] popcount(input logic [DEF_N_IN-1:0] v);
        logic [DEF_CNT_W-1:0] c;
        c = {DEF_CNT_W{1'b0}};
        for (int i = 0; i < DEF_N_IN; i++) begin
            c = c + {{(DEF_CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Result counters clamp at all-ones instead of wrapping.
    function automatic logic [DEF_CNT_W-1:0] sat_add(input logic [DEF_CNT_W-1:0] a,
                                                     input logic [DEF_CNT_W-1:0] b);
        logic [DEF_CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DEF_CNT_W] ? {DEF_CNT_W{1'b1}} : s[DEF_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/power_vec_gen.sv
// Vector index generator: holds the current index and order, and presents the
// following vector (binary or Gray, wrapping modulo 2^N_IN).
module power_vec_gen
    import power_sched_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            adv,
    input  logic            mode,
    output logic [N_IN-1:0] next_vec
);

    logic [N_IN-1:0] idx_q, idx_d, idx_nxt_s;
    logic            mode_q, mode_d;

    // Next index and mode; load restarts the walk at index 0.
    always_comb begin
        idx_nxt_s = idx_q + {{(N_IN-1){1'b0}}, 1'b1};
        if (load) begin
            idx_d  = {N_IN{1'b0}};
            mode_d = mode;
        end else if (adv) begin
            idx_d  = idx_nxt_s;
            mode_d = mode_q;
        end else begin
            idx_d  = idx_q;
            mode_d = mode_q;
        end
        next_vec = (mode_q == MODE_GRAY) ? (idx_nxt_s ^ (idx_nxt_s >> 1)) : idx_nxt_s;
    end

    // Index and order registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= {N_IN{1'b0}};
            mode_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            mode_q <= mode_d;
        end
    end

endmodule

// File: rtl/power_vec_scheduler.sv
// Walks input vectors into a 4-input sub-circuit, samples its output after a
// settle window and accumulates toggle/ones statistics for power profiling.
module power_vec_scheduler
    import power_sched_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] num_vec,
    input  logic             abort,
    output logic             busy,
    output logic [N_IN-1:0]  dut_in,
    input  logic             dut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] out_toggles,
    output logic [CNT_W-1:0] in_toggles,
    output logic [CNT_W-1:0] out_ones
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYC);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    FULL_LAST   = CNT_W'((1 << N_IN) - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};

    state_e              state_q, state_d;
    logic                busy_q, busy_d;
    logic                res_valid_q, res_valid_d;
    logic [N_IN-1:0]     dut_in_q, dut_in_d;
    logic [CNT_W-1:0]    out_tog_q, out_tog_d;
    logic [CNT_W-1:0]    in_tog_q, in_tog_d;
    logic [CNT_W-1:0]    ones_q, ones_d;
    logic                prev_out_q, prev_out_d;
    logic                first_q, first_d;
    logic [CNT_W-1:0]    samp_cnt_q, samp_cnt_d;
    logic [CNT_W-1:0]    last_idx_q, last_idx_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;

    logic                gen_load_s, gen_adv_s, abort_hit_s;
    logic [N_IN-1:0]     next_vec_s;

    power_vec_gen #(.N_IN(N_IN)) u_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gen_load_s),
        .adv      (gen_adv_s),
        .mode     (mode),
        .next_vec (next_vec_s)
    );

    // Sequencer next-state and counter update logic.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;
        dut_in_d    = dut_in_q;
        out_tog_d   = out_tog_q;
        in_tog_d    = in_tog_q;
        ones_d      = ones_q;
        prev_out_d  = prev_out_q;
        first_d     = first_q;
        samp_cnt_d  = samp_cnt_q;
        last_idx_d  = last_idx_q;
        settle_d    = settle_q;
        gen_load_s  = 1'b0;
        gen_adv_s   = 1'b0;
        abort_hit_s = abort && ((state_q == ST_SETTLE) || (state_q == ST_SAMPLE));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_SETTLE;
                    busy_d      = 1'b1;
                    res_valid_d = 1'b0;
                    dut_in_d    = {N_IN{1'b0}};
                    out_tog_d   = CNT_ZERO;
                    in_tog_d    = CNT_ZERO;
                    ones_d      = CNT_ZERO;
                    prev_out_d  = 1'b0;
                    first_d     = 1'b1;
                    samp_cnt_d  = CNT_ZERO;
                    last_idx_d  = (num_vec == CNT_ZERO) ? FULL_LAST : (num_vec - CNT_ONE);
                    settle_d    = SETTLE_LOAD;
                    gen_load_s  = 1'b1;
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (settle_q <= SETTLE_ONE) begin
                    state_d = ST_SAMPLE;
                end else begin
                    settle_d = settle_q - SETTLE_ONE;
                end
            end
            ST_SAMPLE: begin
                ones_d     = sat_add(ones_q, {{(CNT_W-1){1'b0}}, dut_out});
                out_tog_d  = first_q ? out_tog_q
                                     : sat_add(out_tog_q, {{(CNT_W-1){1'b0}}, dut_out ^ prev_out_q});
                prev_out_d = dut_out;
                first_d    = 1'b0;
                if (samp_cnt_q == last_idx_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d    = ST_SETTLE;
                    samp_cnt_d = samp_cnt_q + CNT_ONE;
                    gen_adv_s  = 1'b1;
                    dut_in_d   = next_vec_s;
                    in_tog_d   = sat_add(in_tog_q, popcount(next_vec_s ^ dut_in_q));
                    settle_d   = SETTLE_LOAD;
                end
            end
            ST_DONE: begin
                // res_valid follows DONE by one cycle so counters are final when it rises.
                if (res_valid_q && res_ready) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    res_valid_d = 1'b0;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase

        if (abort_hit_s) begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            res_valid_d = 1'b0;
            dut_in_d    = {N_IN{1'b0}};
            out_tog_d   = CNT_ZERO;
            in_tog_d    = CNT_ZERO;
            ones_d      = CNT_ZERO;
            gen_adv_s   = 1'b0;
        end else begin
            gen_adv_s = gen_adv_s;
        end
    end

    // State, outputs and counters; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            dut_in_q    <= {N_IN{1'b0}};
            out_tog_q   <= CNT_ZERO;
            in_tog_q    <= CNT_ZERO;
            ones_q      <= CNT_ZERO;
            prev_out_q  <= 1'b0;
            first_q     <= 1'b0;
            samp_cnt_q  <= CNT_ZERO;
            last_idx_q  <= CNT_ZERO;
            settle_q    <= {SETTLE_W{1'b0}};
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
            dut_in_q    <= dut_in_d;
            out_tog_q   <= out_tog_d;
            in_tog_q    <= in_tog_d;
            ones_q      <= ones_d;
            prev_out_q  <= prev_out_d;
            first_q     <= first_d;
            samp_cnt_q  <= samp_cnt_d;
            last_idx_q  <= last_idx_d;
            settle_q    <= settle_d;
        end
    end

    assign busy        = busy_q;
    assign res_valid   = res_valid_q;
    assign dut_in      = dut_in_q;
    assign out_toggles = out_tog_q;
    assign in_toggles  = in_tog_q;
    assign out_ones    = ones_q;

endmodule

// File: tb/tb_power_vec_scheduler.sv
// Self-checking bench: table-driven runs, handshake/abort/reset sequences and
// randomized runs compared against a behavioural model of the vector walk.
module tb_power_vec_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode, abort, res_ready;
    logic [15:0] num_vec;
    logic        busy, res_valid, dut_out;
    logic [3:0]  dut_in;
    logic [15:0] out_toggles, in_toggles, out_ones;

    int n_cmp = 0;
    int n_err = 0;
    int obs[$];
    int exp_seq[$];

    typedef struct {
        bit mode;
        int num;
        int lat;
        int ot;
        int it;
        int ones;
    } vec_t;
    vec_t tbl[4];

    power_vec_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .num_vec(num_vec),
        .abort(abort), .busy(busy), .dut_in(dut_in), .dut_out(dut_out),
        .res_valid(res_valid), .res_ready(res_ready), .out_toggles(out_toggles),
        .in_toggles(in_toggles), .out_ones(out_ones)
    );

    always #5 clk = ~clk;

    function automatic bit f_of(input int v);
        bit a, b, c, d;
        a = v[0]; b = v[1]; c = v[2]; d = v[3];
        return (a ^ d) & (a | (b & c));
    endfunction

    assign dut_out = f_of(int'(dut_in));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the vectors arithmetically and accumulate the statistics.
    task automatic model(input bit m, input int n, output int lat, output int ot,
                         output int it, output int ones);
        int total, v, pv, o, po;
        total = (n == 0) ? 16 : n;
        ot = 0; it = 0; ones = 0; pv = 0; po = 0;
        exp_seq.delete();
        for (int k = 0; k < total; k++) begin
            v = k % 16;
            if (m) v = v ^ (v >> 1);
            o = int'(f_of(v));
            if (k > 0) begin
                ot += (o != po) ? 1 : 0;
                it += $countones(v ^ pv);
            end
            ones += o;
            exp_seq.push_back(v);
            pv = v; po = o;
        end
        lat = 2 * total + 1;
    endtask

    task automatic do_run(input string tag, input bit m, input int n, input int e_lat,
                          input int e_ot, input int e_it, input int e_ones);
        int lat, budget, bad, ml, mo, mi, mn;
        model(m, n, ml, mo, mi, mn);
        budget = 4 * ((n == 0) ? 16 : n) + 40;
        @(negedge clk);
        start = 1'b1; mode = m; num_vec = 16'(n);
        @(posedge clk); #1;
        start = 1'b0;
        obs.delete();
        obs.push_back(int'(dut_in));
        chk({tag, "_busy_rise"}, busy, 1);
        lat = 0;
        while (!res_valid && lat < budget) begin
            @(posedge clk); #1;
            lat++;
            if (int'(dut_in) != obs[$]) obs.push_back(int'(dut_in));
        end
        chk({tag, "_timeout"}, res_valid, 1);
        chk({tag, "_latency"}, lat, e_lat);
        chk({tag, "_out_toggles"}, out_toggles, e_ot);
        chk({tag, "_in_toggles"}, in_toggles, e_it);
        chk({tag, "_out_ones"}, out_ones, e_ones);
        chk({tag, "_model_out_toggles"}, out_toggles, mo);
        chk({tag, "_model_in_toggles"}, in_toggles, mi);
        chk({tag, "_model_ones"}, out_ones, mn);
        chk({tag, "_seq_len"}, obs.size(), exp_seq.size());
        bad = 0;
        for (int i = 0; i < obs.size() && i < exp_seq.size(); i++)
            if (obs[i] != exp_seq[i]) bad++;
        chk({tag, "_seq_bad_elems"}, bad, 0);
    endtask

    task automatic finish_run(input string tag);
        @(negedge clk) res_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_valid_fall"}, res_valid, 0);
        @(negedge clk) res_ready = 1'b0;
    endtask

    initial begin
        int lat, ot, it, ones, n, cyc, bad;
        bit m;
        tbl[0] = '{1'b0, 0, 33, 10, 26, 5};
        tbl[1] = '{1'b1, 0, 33, 6, 15, 5};
        tbl[2] = '{1'b0, 20, 41, 13, 34, 7};
        tbl[3] = '{1'b0, 1, 3, 0, 0, 0};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0; res_ready = 1'b0; num_vec = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_dut_in", dut_in, 0);
        chk("rst_counters", {out_toggles, in_toggles} | {16'd0, out_ones}, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int t = 0; t < 4; t++) begin
            do_run($sformatf("tbl%0d", t), tbl[t].mode, tbl[t].num, tbl[t].lat,
                   tbl[t].ot, tbl[t].it, tbl[t].ones);
            if (t == 0) begin
                // Hold results with res_ready low; start and abort must be ignored in DONE.
                bad = 0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    start = (c == 3);
                    abort = (c == 6);
                    @(posedge clk); #1;
                    if (!res_valid || !busy || out_toggles != 16'd10 || in_toggles != 16'd26
                        || out_ones != 16'd5 || dut_in != 4'd15) bad++;
                end
                start = 1'b0; abort = 1'b0;
                chk("hold_stable_cycles_bad", bad, 0);
            end
            finish_run($sformatf("tbl%0d", t));
        end

        // Abort while vector 5 is applied.
        @(negedge clk);
        start = 1'b1; mode = 1'b0; num_vec = 16'd0;
        @(negedge clk) start = 1'b0;
        cyc = 0;
        while (dut_in != 4'd5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("abort_reached_vec5", dut_in, 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_dut_in", dut_in, 0);
        chk("abort_valid", res_valid, 0);
        chk("abort_counters", {out_toggles, in_toggles} | {16'd0, out_ones}, 0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (res_valid || busy) bad++;
        end
        chk("abort_stays_idle", bad, 0);
        do_run("post_abort", 1'b0, 0, 33, 10, 26, 5);
        finish_run("post_abort");

        // Asynchronous reset in the middle of a SETTLE cycle.
        @(negedge clk);
        start = 1'b1; mode = 1'b1; num_vec = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_dut_in", dut_in, 0);
        chk("async_rst_valid", res_valid, 0);
        chk("async_rst_counters", {out_toggles, in_toggles} | {16'd0, out_ones}, 0);
        @(negedge clk) rst_n = 1'b1;

        // Randomized runs against the model.
        for (int r = 0; r < 12; r++) begin
            m = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 40));
            model(m, n, lat, ot, it, ones);
            do_run($sformatf("rnd%0d", r), m, n, lat, ot, it, ones);
            finish_run($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
